// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronizes an asynchronous active-low reset, holds
// for a fixed time, then releases CHANNELS active-high resets one by one
// with a fixed gap. Once running, a soft request reruns the hold/release
// sequence without going back through the synchronizer.
module reset_sequencer #(
  parameter int STAGES      = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int CHANNELS    = 4,
  parameter int GAP_CYCLES  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                soft_req,
  output logic                soft_ack,
  output logic [CHANNELS-1:0] reset_sync,
  output logic                reset_done
);

  // One shared counter serves both the hold and the gap phases.
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  logic [STAGES-1:0]   sync_q;
  logic                sync_ok;
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CHANNELS-1:0] reset_sync_q, reset_sync_d;
  logic                reset_done_q, reset_done_d;
  logic                soft_ack_q, soft_ack_d;
  logic [CHANNELS-1:0] released_vec;

  assign sync_ok = sync_q[STAGES-1];

  // Release synchronizer: cleared asynchronously, fills with ones on clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], 1'b1};
    end
  end

  // FSM, counter and output registers; all outputs come straight from here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_ASSERT;
      cnt_q        <= '0;
      reset_sync_q <= '1;
      reset_done_q <= 1'b0;
      soft_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      reset_sync_q <= reset_sync_d;
      reset_done_q <= reset_done_d;
      soft_ack_q   <= soft_ack_d;
    end
  end

  // Next-state logic. Channels release from bit 0 upward by shifting a zero
  // in at the bottom, so a released bit can never come back on its own.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    reset_sync_d = reset_sync_q;
    reset_done_d = reset_done_q;
    soft_ack_d   = 1'b0;
    released_vec = reset_sync_q << 1;

    case (state_q)
      ST_ASSERT: begin
        if (sync_ok) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end

      ST_HOLD, ST_RELEASE: begin
        if ((state_q == ST_HOLD    && cnt_q == HOLD_LAST) ||
            (state_q == ST_RELEASE && cnt_q == GAP_LAST)) begin
          reset_sync_d = released_vec;
          cnt_d        = '0;
          if (released_vec == '0) begin
            state_d      = ST_RUN;
            reset_done_d = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (soft_req) begin
          state_d      = ST_HOLD;
          cnt_d        = '0;
          reset_sync_d = '1;
          reset_done_d = 1'b0;
          soft_ack_d   = 1'b1;
        end
      end

      default: begin
        state_d = ST_ASSERT;
      end
    endcase
  end

  assign reset_sync = reset_sync_q;
  assign reset_done = reset_done_q;
  assign soft_ack   = soft_ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: expected output states are queued against
// edge numbers when a reset/soft request is driven and compared as the
// edges arrive.
module tb_reset_sequencer;

  localparam int H  = 16;
  localparam int G  = 8;
  localparam int CH = 4;

  logic          clk;
  logic          clk_en;
  logic          reset;
  logic          soft_req;
  logic          soft_ack;
  logic [CH-1:0] reset_sync;
  logic          reset_done;

  logic          reset2;
  logic          soft_req2;
  logic          soft_ack2;
  logic [0:0]    reset_sync2;
  logic          reset_done2;

  int n_tests;
  int n_fail;
  int edge_n;
  int ack_seen;
  int pos_cnt;

  typedef struct {
    int          edge_no;
    logic [3:0]  sync;
    logic        done;
    logic        ack;
  } exp_t;

  exp_t exp_q[$];

  reset_sequencer #(
    .STAGES(2), .HOLD_CYCLES(H), .CHANNELS(CH), .GAP_CYCLES(G)
  ) dut (
    .clk(clk), .reset(reset), .soft_req(soft_req), .soft_ack(soft_ack),
    .reset_sync(reset_sync), .reset_done(reset_done)
  );

  reset_sequencer #(
    .STAGES(3), .HOLD_CYCLES(1), .CHANNELS(1), .GAP_CYCLES(1)
  ) dut2 (
    .clk(clk), .reset(reset2), .soft_req(soft_req2), .soft_ack(soft_ack2),
    .reset_sync(reset_sync2), .reset_done(reset_done2)
  );

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;
  always @(posedge clk) pos_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_exp(input int e, input logic [3:0] s, input logic d, input logic a);
    exp_t x;
    x.edge_no = e;
    x.sync    = s;
    x.done    = d;
    x.ack     = a;
    exp_q.push_back(x);
  endfunction

  // Expected release timeline when HOLD is entered at edge 'base'.
  function automatic void push_seq(input int base);
    logic [3:0] ones;
    logic [3:0] before_v;
    logic [3:0] after_v;
    int rel;
    ones = 4'hF;
    for (int k = 0; k < CH; k++) begin
      before_v = ones << k;
      after_v  = ones << (k + 1);
      rel      = base + H + k * G;
      push_exp(rel - 1, before_v, 1'b0, 1'b0);
      push_exp(rel, after_v, k == CH - 1, 1'b0);
    end
  endfunction

  // Advance one edge, sample #1 later and compare any expectation due now.
  task automatic step();
    exp_t x;
    @(posedge clk);
    #1;
    edge_n++;
    if (soft_ack) ack_seen++;
    while (exp_q.size() > 0 && exp_q[0].edge_no <= edge_n) begin
      x = exp_q.pop_front();
      check_eq($sformatf("sync_e%0d", x.edge_no), 32'(reset_sync), 32'(x.sync));
      check_eq($sformatf("done_e%0d", x.edge_no), 32'(reset_done), 32'(x.done));
      check_eq($sformatf("ack_e%0d", x.edge_no), 32'(soft_ack), 32'(x.ack));
      $display("[TB] edge %0d: sync=%b done=%b ack=%b (exp %b %b %b)",
               x.edge_no, reset_sync, reset_done, soft_ack, x.sync, x.done, x.ack);
    end
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) step();
  endtask

  // Pulse reset low between edges, check the asynchronous assert, release at negedge.
  task automatic restart(input string tag);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_eq({tag, "_async_sync"}, 32'(reset_sync), 32'hF);
    check_eq({tag, "_async_done"}, 32'(reset_done), 32'h0);
    @(negedge clk);
    reset  = 1'b1;
    edge_n = 0;
    exp_q.delete();
  endtask

  initial begin
    int pos_before;
    n_tests   = 0;
    n_fail    = 0;
    edge_n    = 0;
    ack_seen  = 0;
    pos_cnt   = 0;
    clk_en    = 1'b1;
    reset     = 1'b0;
    reset2    = 1'b0;
    soft_req  = 1'b0;
    soft_req2 = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_sync", 32'(reset_sync), 32'hF);
    check_eq("rst_done", 32'(reset_done), 32'h0);
    check_eq("rst_ack", 32'(soft_ack), 32'h0);
    check_eq("rst_sync2", 32'(reset_sync2), 32'h1);

    // Parameter sweep: STAGES=3, HOLD=1, CH=1, GAP=1 -> change at edge 5
    @(negedge clk);
    reset2 = 1'b1;
    edge_n = 0;
    run_to(4);
    check_eq("sweep_sync_e4", 32'(reset_sync2), 32'h1);
    check_eq("sweep_done_e4", 32'(reset_done2), 32'h0);
    step();
    check_eq("sweep_sync_e5", 32'(reset_sync2), 32'h0);
    check_eq("sweep_done_e5", 32'(reset_done2), 32'h1);
    $display("[TB] sweep: sync=%b done=%b at edge 5", reset_sync2, reset_done2);

    // Power-on sequence
    @(negedge clk);
    reset  = 1'b1;
    edge_n = 0;
    push_seq(3);
    step();
    check_eq("pon_sync_ok_e1", 32'(dut.sync_ok), 32'h0);
    step();
    check_eq("pon_sync_ok_e2", 32'(dut.sync_ok), 32'h1);
    run_to(43);

    // Soft reset accepted in RUN at edge T=46
    push_exp(45, 4'h0, 1'b1, 1'b0);
    push_exp(46, 4'hF, 1'b0, 1'b1);
    push_exp(47, 4'hF, 1'b0, 1'b0);
    push_seq(46);
    push_exp(90, 4'h0, 1'b1, 1'b0);
    run_to(45);
    soft_req = 1'b1;
    step();
    soft_req = 1'b0;
    run_to(90);
    check_eq("soft_queue_empty", 32'(exp_q.size()), 32'h0);

    // Request during HOLD/RELEASE is ignored, timeline unchanged
    restart("ign");
    push_seq(3);
    run_to(4);
    ack_seen = 0;
    soft_req = 1'b1;
    run_to(42);
    soft_req = 1'b0;
    run_to(44);
    check_eq("ign_ack_count", 32'(ack_seen), 32'h0);

    // 1 ns reset glitch at edge 30 restarts the full sequence
    restart("mid_pre");
    push_seq(3);
    run_to(30);
    exp_q.delete();
    reset = 1'b0;
    #1;
    check_eq("mid_glitch_sync", 32'(reset_sync), 32'hF);
    check_eq("mid_glitch_done", 32'(reset_done), 32'h0);
    reset  = 1'b1;
    edge_n = 0;
    push_seq(3);
    step();
    check_eq("mid_sync_ok_e1", 32'(dut.sync_ok), 32'h0);
    step();
    check_eq("mid_sync_ok_e2", 32'(dut.sync_ok), 32'h1);
    run_to(45);
    check_eq("mid_queue_empty", 32'(exp_q.size()), 32'h0);

    // Clockless assert: stop clk in RUN, drop reset
    check_eq("noclk_pre_done", 32'(reset_done), 32'h1);
    @(negedge clk);
    clk_en     = 1'b0;
    #7;
    pos_before = pos_cnt;
    reset      = 1'b0;
    #3;
    check_eq("noclk_sync", 32'(reset_sync), 32'hF);
    check_eq("noclk_done", 32'(reset_done), 32'h0);
    #20;
    check_eq("noclk_no_edges", 32'(pos_cnt), 32'(pos_before));
    $display("[TB] clockless assert: sync=%b done=%b", reset_sync, reset_done);
    reset  = 1'b1;
    clk_en = 1'b1;
    #20;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter STAGES, default 2, synchronizer depth in flops; legal range >=2.
REQ-002 SHALL have parameter HOLD_CYCLES, default 16, reset hold time in clk cycles after synchronized release; legal range >=1.
REQ-003 SHALL have parameter CHANNELS, default 4, number of sequenced reset outputs; legal range >=1.
REQ-004 SHALL have parameter GAP_CYCLES, default 8, clk cycles between consecutive channel releases; legal range >=1.
REQ-005 SHALL have port: clk  input  1  single clock, rising-edge.
REQ-006 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port: soft_req  input  1  synchronous soft-reset request, sampled in RUN only.
REQ-008 SHALL have port: soft_ack  output  1  one-cycle acknowledge of an accepted soft_req.
REQ-009 SHALL have port: reset_sync  output  CHANNELS  active-high synchronized resets; bit 0 releases first.
REQ-010 SHALL have port: reset_done  output  1  high when every reset_sync bit is deasserted.

Function
REQ-011 SHALL implement a STAGES-flop chain, asynchronously cleared by reset low, shifting in 1 otherwise; last stage = sync_ok.
REQ-012 SHALL make sync_ok rise exactly at the STAGES-th rising clk edge after reset goes high.
REQ-013 SHALL implement FSM states ASSERT, HOLD, RELEASE, RUN.
REQ-014 ASSERT: SHALL move to HOLD at the first edge where sync_ok=1; hold counter cleared on entry.
REQ-015 HOLD: SHALL stay exactly HOLD_CYCLES cycles, then enter RELEASE, deasserting reset_sync[0] at that same edge.
REQ-016 RELEASE: SHALL deassert reset_sync[k] exactly GAP_CYCLES edges after reset_sync[k-1], for k=1..CHANNELS-1.
REQ-017 SHALL enter RUN and raise reset_done on the same edge that deasserts reset_sync[CHANNELS-1]; CHANNELS=1 means RUN is entered at the HOLD-exit edge.
REQ-018 RUN, soft_req=1 at an edge: SHALL set reset_sync to all ones, clear reset_done, pulse soft_ack for that cycle, and enter HOLD without re-running the synchronizer chain.
REQ-019 SHALL ignore soft_req outside RUN; soft_ack stays 0, with no queuing.
REQ-020 Holding soft_req high SHALL produce one ack per RUN entry, i.e. re-trigger at the first RUN edge after each completed sequence.
REQ-021 Once deasserted, reset_sync bits SHALL stay 0 until reset low or an accepted soft_req.
REQ-022 All outputs SHALL be driven directly from flops, with no combinational glitches.
REQ-023 Counter widths SHALL be sized for max(HOLD_CYCLES, GAP_CYCLES) and a channel index of CHANNELS-1, with no wrap in the legal range.

Reset
REQ-024 reset low SHALL asynchronously force: chain all 0, state ASSERT, reset_sync all ones, reset_done 0, soft_ack 0, counters 0.
REQ-025 A reset low pulse of any width, including sub-cycle and mid-HOLD/RELEASE/RUN, SHALL restart the full sequence from REQ-012.
REQ-026 Assertion SHALL not depend on clk running; deassertion SHALL be clk-synchronous only.

Verification (defaults STAGES=2, HOLD=16, CH=4, GAP=8; edge 1 = first rising edge after reset rises)
REQ-027 Power-on: the bench SHALL check that reset rises -> sync_ok at edge 2, HOLD from edge 3, reset_sync[0]/[1]/[2]/[3] fall at edges 19/27/35/43, and reset_done=1 at edge 43.
REQ-028 Soft reset: the bench SHALL check that soft_req=1 in RUN at edge T -> reset_sync=4'b1111, reset_done=0, and soft_ack=1 for one cycle at T, with bit 0 falling at T+16 and reset_done at T+40.
REQ-029 Ignored request: the bench SHALL check that soft_req=1 during HOLD/RELEASE -> soft_ack stays 0 and timing is unchanged from REQ-027.
REQ-030 Mid-sequence reset: the bench SHALL check that a 1 ns reset low glitch at edge 30 -> immediately reset_sync=4'b1111 and reset_done=0, followed by the full REQ-027 timeline from the new rise.
REQ-031 Clockless assert: the bench SHALL check that with clk stopped in RUN, reset low -> reset_sync=all ones without any clk edge.
REQ-032 Parameter sweep: the bench SHALL check that STAGES=3, HOLD=1, CH=1, GAP=1 -> reset_sync[0] and reset_done change at edge 5.
